scan_mux_reg: RTL and testbench

Parametrised, registered N:1 multiplexer that generalises the two-input, 2-bit combinational test mux.
- Selects one of CHANNELS input words of WIDTH bits.
- Selection comes either from a host-loaded select register (manual mode) or from an internal round-robin scanner that dwells DWELL cycles per channel (scan mode).
- Used as a synthesis/BLIF regression target for sequential logic and parameter propagation.

---
 rtl/scan_mux_reg.sv | 100 ++++++++++
 tb/tb_scan_mux_reg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux_reg.sv
// Registered CHANNELS:1 multiplexer. The channel is chosen either by a
// host-loaded select register (manual mode) or by a round-robin scanner.
module scan_mux_reg #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      sel_load,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [WIDTH-1:0]          q,
  output logic [SEL_W-1:0]          q_sel,
  output logic                      q_valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   SEL_LIMIT  = (SEL_W + 1)'(CHANNELS);

  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic             wrap_q, wrap_d;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [SEL_W-1:0] q_sel_q;
  logic             q_valid_q;
  logic             sel_ok;

  assign sel_ok = {1'b0, sel_in} < SEL_LIMIT;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_sel_d   = cur_sel_q;
    dwell_cnt_d = '0;
    wrap_d      = 1'b0;
    sel_err_d   = 1'b0;
    if (sel_load && sel_ok) begin
      cur_sel_d = sel_in;
    end else begin
      sel_err_d = sel_load;
      if (mode) begin
        if (dwell_cnt_q == DWELL_LAST) begin
          if (cur_sel_q == SEL_LAST) begin
            cur_sel_d = '0;
            wrap_d    = 1'b1;
          end else begin
            cur_sel_d = cur_sel_q + SEL_W'(1);
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Only the in-range channel slices are ever routed, so X on other channels never reaches q.
  always_comb begin
    q_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_sel_q == SEL_W'(k)) begin
        q_d = d[k*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel_q   <= '0;
      dwell_cnt_q <= '0;
      wrap_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      q_q         <= '0;
      q_sel_q     <= '0;
      q_valid_q   <= 1'b0;
    end else begin
      cur_sel_q   <= cur_sel_d;
      dwell_cnt_q <= dwell_cnt_d;
      wrap_q      <= wrap_d;
      sel_err_q   <= sel_err_d;
      q_q         <= q_d;
      q_sel_q     <= cur_sel_q;
      q_valid_q   <= 1'b1;
    end
  end

  assign q       = q_q;
  assign q_sel   = q_sel_q;
  assign q_valid = q_valid_q;
  assign wrap    = wrap_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Scoreboard bench for scan_mux_reg: a 4x2-bit instance and a 5x8-bit instance
// share control stimulus; an integer reference model predicts each edge.
module tb_scan_mux_reg;

  localparam int A_W = 2, A_CH = 4, A_SW = 2, A_DW = 3;
  localparam int B_W = 8, B_CH = 5, B_SW = 3, B_DW = 3;

  logic clk, rst_n, mode, sel_load;
  logic [A_SW-1:0]      sel_in_a;
  logic [B_SW-1:0]      sel_in_b;
  logic [A_CH*A_W-1:0]  d_a;
  logic [B_CH*B_W-1:0]  d_b;
  logic [A_W-1:0]       q_a;
  logic [B_W-1:0]       q_b;
  logic [A_SW-1:0]      q_sel_a;
  logic [B_SW-1:0]      q_sel_b;
  logic q_valid_a, q_valid_b, wrap_a, wrap_b, sel_err_a, sel_err_b;

  scan_mux_reg #(.WIDTH(A_W), .CHANNELS(A_CH), .SEL_W(A_SW), .DWELL(A_DW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_load(sel_load), .sel_in(sel_in_a),
    .d(d_a), .q(q_a), .q_sel(q_sel_a), .q_valid(q_valid_a), .wrap(wrap_a), .sel_err(sel_err_a)
  );

  scan_mux_reg #(.WIDTH(B_W), .CHANNELS(B_CH), .SEL_W(B_SW), .DWELL(B_DW)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_load(sel_load), .sel_in(sel_in_b),
    .d(d_b), .q(q_b), .q_sel(q_sel_b), .q_valid(q_valid_b), .wrap(wrap_b), .sel_err(sel_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    int         q_sel;
    bit         valid;
    bit         wrap;
    bit         err;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int m_sel[2];
  int m_held[2];
  logic [A_W-1:0] a_data[A_CH];
  logic [B_W-1:0] b_data[B_CH];

  int checks = 0;
  int errors = 0;
  bit running = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference behaviour: selected channel and cycles spent on it, as plain integers.
  task automatic model_step(input int idx, input int ch, input int dwell, input bit load,
                            input int sel_req, input bit md, input logic [7:0] word,
                            output exp_t e);
    e.q     = word;
    e.q_sel = m_sel[idx];
    e.valid = 1'b1;
    e.wrap  = 1'b0;
    e.err   = 1'b0;
    if (load && sel_req < ch) begin
      m_sel[idx]  = sel_req;
      m_held[idx] = 0;
    end else begin
      if (load) e.err = 1'b1;
      if (md) begin
        if (m_held[idx] == dwell - 1) begin
          m_held[idx] = 0;
          if (m_sel[idx] == ch - 1) e.wrap = 1'b1;
          m_sel[idx] = (m_sel[idx] + 1) % ch;
        end else begin
          m_held[idx]++;
        end
      end else begin
        m_held[idx] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i]  = 0;
      m_held[i] = 0;
    end
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic pack_data();
    for (int k = 0; k < A_CH; k++) d_a[k*A_W +: A_W] = a_data[k];
    for (int k = 0; k < B_CH; k++) d_b[k*B_W +: B_W] = b_data[k];
  endtask

  task automatic rand_data();
    for (int k = 0; k < A_CH; k++) a_data[k] = A_W'($urandom);
    for (int k = 0; k < B_CH; k++) b_data[k] = B_W'($urandom);
  endtask

  // Drive one cycle of stimulus, predict the coming edge, then advance to negedge+1.
  task automatic step(input bit ld, input int sa, input int sb, input bit md);
    exp_t e;
    sel_load = ld;
    sel_in_a = sa[A_SW-1:0];
    sel_in_b = sb[B_SW-1:0];
    mode     = md;
    pack_data();
    model_step(0, A_CH, A_DW, ld, sa, md, {6'b0, a_data[m_sel[0]]}, e);
    exp_a.push_back(e);
    model_step(1, B_CH, B_DW, ld, sb, md, b_data[m_sel[1]], e);
    exp_b.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_q"},       32'(q_a),       0);
    check({tag, "_a_q_sel"},   32'(q_sel_a),   0);
    check({tag, "_a_valid"},   32'(q_valid_a), 0);
    check({tag, "_a_wrap"},    32'(wrap_a),    0);
    check({tag, "_a_sel_err"}, 32'(sel_err_a), 0);
    check({tag, "_b_q"},       32'(q_b),       0);
    check({tag, "_b_q_sel"},   32'(q_sel_b),   0);
    check({tag, "_b_valid"},   32'(q_valid_b), 0);
    check({tag, "_b_wrap"},    32'(wrap_b),    0);
    check({tag, "_b_sel_err"}, 32'(sel_err_b), 0);
  endtask

  // Called at negedge+1: reset is asserted between edges and held across one rising edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    model_reset();
    @(negedge clk);
    #1;
    check_zero("mid_rst_hold");
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (running) begin
      if (exp_a.size() == 0) begin
        check("a_idle_valid", 32'(q_valid_a), 0);
      end else begin
        e = exp_a.pop_front();
        check("a_q",       32'(q_a),       32'(e.q));
        check("a_q_sel",   32'(q_sel_a),   e.q_sel);
        check("a_valid",   32'(q_valid_a), 32'(e.valid));
        check("a_wrap",    32'(wrap_a),    32'(e.wrap));
        check("a_sel_err", 32'(sel_err_a), 32'(e.err));
      end
      if (exp_b.size() == 0) begin
        check("b_idle_valid", 32'(q_valid_b), 0);
      end else begin
        e = exp_b.pop_front();
        check("b_q",       32'(q_b),       32'(e.q));
        check("b_q_sel",   32'(q_sel_b),   e.q_sel);
        check("b_valid",   32'(q_valid_b), 32'(e.valid));
        check("b_wrap",    32'(wrap_b),    32'(e.wrap));
        check("b_sel_err", 32'(sel_err_b), 32'(e.err));
      end
    end
  end

  initial begin
    bit md;
    rst_n    = 1'b1;
    mode     = 1'b0;
    sel_load = 1'b0;
    sel_in_a = '0;
    sel_in_b = '0;
    for (int k = 0; k < A_CH; k++) a_data[k] = A_W'(k);
    for (int k = 0; k < B_CH; k++) b_data[k] = B_W'(8'h10 * (k + 1) + k);
    pack_data();
    model_reset();

    #1 rst_n = 1'b0;
    #1 check_zero("rst");
    repeat (2) @(negedge clk);
    #1;
    check_zero("rst_hold");
    rst_n = 1'b1;
    #1 check_zero("pre_edge");

    // Manual mode, channel 0 after the first edge.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Manual load of channel 2, then a data change on that channel.
    step(1, 2, 2, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    a_data[2] = 2'b01;
    b_data[2] = 8'hA5;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Out-of-range loads on the 5-channel instance; in-range on the other.
    step(1, 1, 5, 0);
    step(0, 0, 0, 0);
    step(1, 3, 7, 0);
    step(0, 0, 0, 0);

    // Scan from channel 0 across several wraps with changing data.
    step(1, 0, 0, 0);
    for (int i = 0; i < 36; i++) begin
      rand_data();
      step(0, 0, 0, 1);
    end

    // Load channel 1 on the second cycle of channel 3 while scanning.
    for (int i = 0; i < 20; i++) begin
      if (m_sel[0] == 3 && m_held[0] == 1) break;
      rand_data();
      step(0, 0, 0, 1);
    end
    check("reached_ch3_dwell1", 32'(m_sel[0] == 3 && m_held[0] == 1), 1);
    step(1, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Out-of-range load while scanning: scanner keeps going.
    step(1, 2, 6, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // Mid-scan asynchronous reset, then scanning restarts from channel 0.
    mid_reset();
    for (int i = 0; i < 20; i++) begin
      rand_data();
      step(0, 0, 0, 1);
    end

    // Randomised mix of mode switches, loads and data.
    md = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) md = ~md;
      rand_data();
      step(($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)), md);
      if (i == 200) begin
        mid_reset();
      end
    end

    running = 1'b0;
    check("a_queue_drained", 32'(exp_a.size()), 0);
    check("b_queue_drained", 32'(exp_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
